// File: rtl/frame_loader.sv
// Raster pixel loader: writes one frame into the image RAM in row-major order, then starts the convolution core.
// Optional statistics counters (frame_cnt, err_cnt) are built when LOADER_STATS_EN is defined.
module frame_loader #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              busy,
    output logic              frame_err,
    output logic [1:0]        dbg_state
`ifdef LOADER_STATS_EN
   ,output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`endif
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XW-1:0]     r_x;
    logic [XW-1:0]     w_x_nxt;
    logic [YW-1:0]     r_y;
    logic [YW-1:0]     w_y_nxt;
    logic              w_xfer;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_we;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_pix_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_conv_start;
    logic              r_err;

    // A pixel moves on a rising edge where s_valid and s_ready are both high; the source
    // holds s_data/s_sof/s_eol stable while s_valid is high and s_ready is low.
    assign s_ready    = rstn && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    assign w_xfer     = s_valid && s_ready;
    assign w_x_last   = (r_x == XW'(IMG_W - 1));
    assign w_y_last   = (r_y == YW'(IMG_H - 1));
    assign w_pix_addr = ADDR_W'(r_y) * ADDR_W'(IMG_W) + ADDR_W'(r_x);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_we        = 1'b0;
        w_err       = 1'b0;
        w_addr      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (s_sof) begin
                        w_we        = 1'b1;
                        w_x_nxt     = XW'(1);
                        w_y_nxt     = '0;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    if (s_sof) begin
                        // Restart: this pixel becomes (0,0) of a fresh frame
                        w_we    = 1'b1;
                        w_err   = 1'b1;
                        w_x_nxt = XW'(1);
                        w_y_nxt = '0;
                    end else if (s_eol != w_x_last) begin
                        w_err       = 1'b1;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_we   = 1'b1;
                        w_addr = w_pix_addr;
                        if (w_x_last) begin
                            w_x_nxt = '0;
                            if (w_y_last) begin
                                w_y_nxt     = '0;
                                w_state_nxt = ST_START;
                            end else begin
                                w_y_nxt = r_y + 1'b1;
                            end
                        end else begin
                            w_x_nxt = r_x + 1'b1;
                        end
                    end
                end
            end
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (conv_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 8'd0;
            r_conv_start <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_we         <= w_we;
            r_err        <= w_err;
            // Delayed a cycle so the start lands after the final write is in RAM
            r_conv_start <= (r_state == ST_START);
            if (w_we) begin
                r_addr  <= w_addr;
                r_wdata <= s_data;
            end
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign conv_start = r_conv_start;
    assign frame_err  = r_err;
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

`ifdef LOADER_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            if (r_state == ST_START) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader (4x4 image): a pixel-index reference model feeds an event
// queue that a negedge monitor drains whenever the loader writes, errors or starts.
module tb_frame_loader;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          s_valid   = 1'b0;
    logic          s_sof     = 1'b0;
    logic          s_eol     = 1'b0;
    logic          conv_done = 1'b0;
    logic [7:0]    s_data    = 8'd0;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          conv_start;
    logic          busy;
    logic          frame_err;
    logic [1:0]    dbg_state;
`ifdef LOADER_STATS_EN
    logic [15:0]   frame_cnt;
    logic [15:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Event word: {we, err, start, addr[3:0], data[7:0]}
    logic [14:0] exp_q[$];

    // Reference model state: inside a frame or not, and linear pixel index within it
    bit m_in     = 1'b0;
    int m_p      = 0;
    int m_frames = 0;
    int m_errs   = 0;

    always #5 clk = ~clk;

    frame_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .busy       (busy),
        .frame_err  (frame_err),
        .dbg_state  (dbg_state)
`ifdef LOADER_STATS_EN
       ,.frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] ev(input bit we, input bit err, input bit st,
                                       input int addr, input logic [7:0] d);
        logic [3:0] a;
        a = 4'(addr);
        return {we, err, st, (we ? a : 4'd0), (we ? d : 8'd0)};
    endfunction

    // Behaviour of one accepted pixel, expressed as a frame-level index walk
    task automatic model(input logic [7:0] d, input bit sof, input bit eol);
        if (!m_in) begin
            if (sof) begin
                exp_q.push_back(ev(1, 0, 0, 0, d));
                m_p  = 1;
                m_in = 1'b1;
            end else begin
                exp_q.push_back(ev(0, 1, 0, 0, d));
                m_errs++;
            end
        end else if (sof) begin
            exp_q.push_back(ev(1, 1, 0, 0, d));
            m_errs++;
            m_p = 1;
        end else if (eol != ((m_p % W) == W - 1)) begin
            exp_q.push_back(ev(0, 1, 0, 0, d));
            m_errs++;
            m_in = 1'b0;
        end else begin
            exp_q.push_back(ev(1, 0, 0, m_p, d));
            m_p++;
            if (m_p == NPIX) begin
                exp_q.push_back(ev(0, 0, 1, 0, 8'd0));
                m_frames++;
                m_in = 1'b0;
            end
        end
    endtask

    logic [14:0] mon_act;
    logic [14:0] mon_exp;
    always @(negedge clk) begin
        if (rstn && (mem_we === 1'b1 || frame_err === 1'b1 || conv_start === 1'b1)) begin
            mon_act = {mem_we, frame_err, conv_start,
                       (mem_we ? mem_addr : 4'd0), (mem_we ? mem_wdata : 8'd0)};
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(mon_act), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("event", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the pixel
    task automatic send(input logic [7:0] d, input bit sof, input bit eol, input int gap_max);
        int g;
        int cnt;
        bit ok;
        g = $urandom_range(0, gap_max);
        s_valid = 1'b0;
        repeat (g) begin
            conv_done = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
        end
        conv_done = 1'b0;
        s_valid   = 1'b1;
        s_data    = d;
        s_sof     = sof;
        s_eol     = eol;
        cnt = 0;
        ok  = 1'b0;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            cnt++;
        end while (!ok && cnt < 200);
        if (!ok) chk("xfer_timeout", 32'(ok), 32'd1);
        else model(d, sof, eol);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic finish_frame();
        int n;
        @(negedge clk);
        chk("start_early", 32'(conv_start), 32'd0);
        @(negedge clk);
        chk("start_latency", 32'(conv_start), 32'd1);
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = 8'($urandom);
        n = $urandom_range(1, 5);
        repeat (n) begin
            @(negedge clk);
            chk("hold_ready", 32'(s_ready), 32'd0);
        end
        @(posedge clk);
        #1 conv_done = 1'b1;
        @(posedge clk);
        #1 conv_done = 1'b0;
        @(negedge clk);
        chk("ready_after_done", 32'(s_ready), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic good_frame(input int gap);
        for (int i = 0; i < NPIX; i++) send(8'($urandom), (i == 0), ((i % W) == W - 1), gap);
        finish_frame();
    endtask

    task automatic bad_eol_frame(input int k, input int gap);
        for (int i = 0; i <= k; i++) begin
            if (i < k) send(8'($urandom), (i == 0), ((i % W) == W - 1), gap);
            else       send(8'($urandom), 1'b0, ((i % W) != W - 1), gap);
        end
    endtask

    task automatic restart_frame(input int r, input int gap);
        for (int i = 0; i < r; i++) send(8'($urandom), (i == 0), ((i % W) == W - 1), gap);
        send(8'($urandom), 1'b1, 1'b0, gap);
        for (int i = 1; i < NPIX; i++) send(8'($urandom), 1'b0, ((i % W) == W - 1), gap);
        finish_frame();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        s_valid   = 1'b0;
        conv_done = 1'b0;
        exp_q.delete();
        m_in     = 1'b0;
        m_p      = 0;
        m_frames = 0;
        m_errs   = 0;
        @(negedge clk);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_start", 32'(conv_start), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
`ifdef LOADER_STATS_EN
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // Back-to-back clean frame, then a frame with a misplaced eol, then a clean one
        good_frame(0);
        bad_eol_frame(6, 1);
        good_frame(1);
        // Mid-frame sof restart at pixel 7
        restart_frame(7, 1);
        // Stray pixel with no sof while idle
        send(8'($urandom), 1'b0, 1'b0, 1);
        // Reset mid-frame after nine accepted pixels
        for (int i = 0; i < 9; i++) send(8'($urandom), (i == 0), ((i % W) == W - 1), 3);
        do_reset();
        good_frame(2);
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0:       good_frame($urandom_range(0, 2));
                1:       bad_eol_frame($urandom_range(1, NPIX - 1), $urandom_range(0, 2));
                2:       restart_frame($urandom_range(1, NPIX - 1), $urandom_range(0, 2));
                default: send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 2);
            endcase
        end
        // Fixed mix of three good and two bad frames from a clean reset
        do_reset();
        good_frame(0);
        bad_eol_frame(6, 0);
        good_frame(1);
        send(8'($urandom), 1'b0, 1'b0, 0);
        good_frame(2);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef LOADER_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        chk("err_cnt", 32'(err_cnt), 32'(m_errs));
        chk("frame_cnt_three", 32'(frame_cnt), 32'd3);
        chk("err_cnt_two", 32'(err_cnt), 32'd2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
